csa_operand_packer: RTL and testbench
=====================================

# csa_operand_packer

Sequential front end for the three-operand carry-save adder stage. It accepts a serial stream of N-bit operands over a valid/ready handshake and groups them into triples in arrival order. Each triple is presented as registered a/b/c operands with its own valid/ready handshake. A short final group, marked by in_last, is zero-padded so the adder sums only real operands.

## Interface
- N, default 8: operand width; equals the width parameter of the downstream adder.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_data  in  N  incoming operand
- in_valid  in  1  in_data/in_last valid this cycle
- in_last  in  1  beat closes the current group, even if fewer than 3 operands
- in_ready  out  1  packer accepts a beat this cycle
- out_a  out  N  first operand of group
- out_b  out  N  second operand, 0 if absent
- out_c  out  N  third operand, 0 if absent
- out_count  out  2  number of real operands in group (1..3)
- out_last  out  1  group was closed by in_last
- out_valid  out  1  output group valid
- out_ready  in  1  downstream accepts group

## Operation
- An input beat is accepted when in_valid && in_ready. An output group transfers when out_valid && out_ready.
- out_free = !out_valid || out_ready: the output register can load at this edge.
- Collect registers are slot0 and slot1. A group completes on the 3rd accepted beat, or on any accepted beat with in_last=1.
- The FSM has four states:
  - FILL0: no operands held.
  - FILL1: slot0 held.
  - FILL2: slot0 and slot1 held.
  - HOLD: complete group parked, waiting for the output register.
- Non-completing accept: FILL0→FILL1 writes slot0; FILL1→FILL2 writes slot1.
- Completing accept with out_free=1: the output register loads {held slots, current beat} directly, zero-filling unused positions. State returns to FILL0.
- Completing accept with out_free=0: the beat is parked (third slot register), and state moves to HOLD.
- HOLD: in_ready=0. When out_free=1, the output loads from the parked group and state goes to FILL0.
- in_ready = rst_n && (state != HOLD). It is combinational from state only, with no dependence on out_ready.
- Order is fixed: 1st accepted beat → out_a, 2nd → out_b, 3rd → out_c.
- out_count equals the number of accepted beats in the group.
- out_last=1 only if the completing beat had in_last=1. A 3rd beat carrying in_last=1 gives out_count=3, out_last=1.
- Output register holds:
  - While out_valid=1 && out_ready=0, out_a/b/c/count/last stay stable.
  - out_valid stays high until the group is accepted.
- The packer performs no arithmetic. Overflow of the adder's N+1-bit result (possible when the sum exceeds 2^(N+1)-1) is the adder/consumer's concern.
- Reset (rst_n=0 at an edge), including mid-group or in HOLD:
  - State returns to FILL0 and any partial or parked group is discarded.
  - out_valid=0; out_a/b/c=0; out_count=0; out_last=0.
  - in_ready=0 while rst_n=0, and is 1 in the first cycle after release.

## Timing
- Latency: when the completing beat is accepted at edge t with out_free, out_valid=1 in cycle t+1.
- Throughput: with out_ready held 1, one operand is accepted per cycle, in_ready never drops, and full groups issue one per 3 cycles.
- Groups of 1 (in_last on first beat) issue one per cycle.
- Back-to-back: a new group loads at the same edge the previous one is taken (out_valid && out_ready). out_valid then stays 1 with no bubble.
- HOLD exit: when out_free occurs in cycle h, the edge ending h loads the output; in_ready=1 from cycle h+1.
- No combinational path from in_* to out_*. The only combinational path is state→in_ready.

## Test plan
- Reset, then stream 1,2,3 with out_ready=1 → one cycle after the 3rd beat: out_a=1, out_b=2, out_c=3, out_count=3, out_last=0; in_ready stays 1 throughout.
- Stream 0xFF,0x10 with in_last on 0x10 → out_a=0xFF, out_b=0x10, out_c=0, out_count=2, out_last=1. Next group starts at out_a.
- out_ready=0; stream 4,5,6 then 7,8,9:
  - Group {4,5,6} is presented; group {7,8,9} parks in HOLD and in_ready=0 after beat 9.
  - Raise out_ready for one cycle → {7,8,9} is presented the next cycle; in_ready=1 the cycle after out_ready rose.
- Continuous stream 1..9 with out_ready=1 → groups {1,2,3}, {4,5,6}, {7,8,9} issue every 3 cycles with no in_ready deassertion.
- Single-beat groups: 0xAA, 0xBB, each with in_last=1, on consecutive cycles, out_ready=1 → out_valid high two consecutive cycles, out_count=1, out_b=out_c=0.
- Accept 1,2, then assert rst_n=0 for one cycle; then send 3,4,5 → first group out is {3,4,5}. out_valid=0 and in_ready=0 during reset.

Source files
------------

// File: rtl/csa_operand_packer_if.sv
// Handshake bundle between the operand stream source, the packer and the
// downstream three-operand carry-save adder.
interface csa_operand_packer_if #(
  parameter int N = 8
);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;
  logic [N-1:0] out_c;
  logic [1:0]   out_count;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  // Packer side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_a, out_b, out_c, out_count, out_last, out_valid
  );

  // Stream source and group consumer side.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_a, out_b, out_c, out_count, out_last, out_valid
  );
endinterface

// File: rtl/csa_operand_packer.sv
// Groups a serial operand stream into registered a/b/c triples for the CSA
// stage; short groups closed by in_last are zero-padded.
module csa_operand_packer #(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst_n,
  csa_operand_packer_if.slave bus
);

  typedef enum logic [1:0] {FILL0, FILL1, FILL2, HOLD} state_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [1:0]   count;
    logic         last;
  } grp_t;

  state_t       state_q, state_d;
  logic [N-1:0] slot0_q, slot1_q;
  grp_t         park_q;
  grp_t         out_q;
  logic         out_vld_q;

  logic         in_rdy;
  logic         acc;
  logic         out_free;
  logic         complete;
  grp_t         grp_now;
  logic         wr_slot0, wr_slot1, park_en, load_new, load_park;

  // in_ready depends on state and reset only, never on out_ready.
  assign in_rdy   = rst_n && (state_q != HOLD);
  assign acc      = bus.in_valid && in_rdy;
  assign out_free = !out_vld_q || bus.out_ready;
  assign complete = acc && (bus.in_last || (state_q == FILL2));

  // Group as it would look if the current beat closed it.
  always_comb begin
    grp_now       = '0;
    grp_now.last  = bus.in_last;
    case (state_q)
      FILL0: begin
        grp_now.a     = bus.in_data;
        grp_now.count = 2'd1;
      end
      FILL1: begin
        grp_now.a     = slot0_q;
        grp_now.b     = bus.in_data;
        grp_now.count = 2'd2;
      end
      FILL2: begin
        grp_now.a     = slot0_q;
        grp_now.b     = slot1_q;
        grp_now.c     = bus.in_data;
        grp_now.count = 2'd3;
      end
      default: grp_now = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wr_slot0  = 1'b0;
    wr_slot1  = 1'b0;
    park_en   = 1'b0;
    load_new  = 1'b0;
    load_park = 1'b0;
    case (state_q)
      FILL0, FILL1, FILL2: begin
        if (complete) begin
          if (out_free) begin
            load_new = 1'b1;
            state_d  = FILL0;
          end else begin
            park_en  = 1'b1;
            state_d  = HOLD;
          end
        end else if (acc) begin
          if (state_q == FILL0) begin
            wr_slot0 = 1'b1;
            state_d  = FILL1;
          end else begin
            wr_slot1 = 1'b1;
            state_d  = FILL2;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          load_park = 1'b1;
          state_d   = FILL0;
        end
      end
      default: state_d = FILL0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL0;
      slot0_q   <= '0;
      slot1_q   <= '0;
      park_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_slot0) slot0_q <= bus.in_data;
      if (wr_slot1) slot1_q <= bus.in_data;
      if (park_en)  park_q  <= grp_now;
      // A new group may load on the same edge the previous one is taken.
      if (load_new) begin
        out_q     <= grp_now;
        out_vld_q <= 1'b1;
      end else if (load_park) begin
        out_q     <= park_q;
        out_vld_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_a     = out_q.a;
  assign bus.out_b     = out_q.b;
  assign bus.out_c     = out_q.c;
  assign bus.out_count = out_q.count;
  assign bus.out_last  = out_q.last;
  assign bus.out_valid = out_vld_q;

  // A presented group must not change or vanish until it is taken.
  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_vld_q && !bus.out_ready) |=> (out_vld_q && $stable(out_q)));

  a_no_accept_in_hold: assert property (@(posedge clk)
    (state_q == HOLD) |-> !in_rdy);

endmodule

// File: tb/tb_csa_operand_packer.sv
// Bench for csa_operand_packer: table of groups with constant expectations,
// a scoreboard queue checked at each output transfer, plus stall/reset cases.
module tb_csa_operand_packer;
  localparam int N = 8;

  typedef struct {
    logic [N-1:0] a, b, c;
    logic [1:0]   count;
    logic         last;
  } grp_t;

  typedef struct {
    int               n;
    logic [2:0][N-1:0] d;
    logic             last;
    grp_t             exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  grp_t sb[$];
  int   xfer_cyc[$];

  csa_operand_packer_if #(.N(N)) bus ();

  csa_operand_packer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Monitor: inputs change at posedge+1, so the negedge sees the values the
  // next edge will act on.
  logic         prev_hold = 1'b0;
  logic [N-1:0] pa, pb, pc;
  logic [1:0]   pcnt;
  logic         plast;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && prev_hold) begin
      checks++;
      if (!bus.out_valid || bus.out_a !== pa || bus.out_b !== pb ||
          bus.out_c !== pc || bus.out_count !== pcnt || bus.out_last !== plast) begin
        errors++;
        $display("FAIL stall_stable: got v=%0b a=%h b=%h c=%h n=%0d l=%0b, want v=1 a=%h b=%h c=%h n=%0d l=%0b",
                 bus.out_valid, bus.out_a, bus.out_b, bus.out_c, bus.out_count, bus.out_last,
                 pa, pb, pc, pcnt, plast);
      end
    end
    prev_hold = rst_n && bus.out_valid && !bus.out_ready;
    pa = bus.out_a; pb = bus.out_b; pc = bus.out_c; pcnt = bus.out_count; plast = bus.out_last;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      xfer_cyc.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_group: got a=%h b=%h c=%h n=%0d, want none",
                 bus.out_a, bus.out_b, bus.out_c, bus.out_count);
      end else begin
        grp_t e;
        e = sb.pop_front();
        if (bus.out_a !== e.a || bus.out_b !== e.b || bus.out_c !== e.c ||
            bus.out_count !== e.count || bus.out_last !== e.last) begin
          errors++;
          $display("FAIL group: got a=%h b=%h c=%h n=%0d l=%0b, want a=%h b=%h c=%h n=%0d l=%0b",
                   bus.out_a, bus.out_b, bus.out_c, bus.out_count, bus.out_last,
                   e.a, e.b, e.c, e.count, e.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [N-1:0] a, b, c, input logic [1:0] n, input logic l);
    grp_t g;
    g.a = a; g.b = b; g.c = c; g.count = n; g.last = l;
    sb.push_back(g);
  endtask

  // Present one beat and return at posedge+1 of the edge that accepted it.
  task automatic send(input logic [N-1:0] d, input logic l);
    bit done;
    done = 0;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, want accept of %h", d);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      step();
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d groups outstanding, want 0", sb.size());
    end
  endtask

  vec_t vt[8];
  int   rdy_drops;

  initial begin
    vt[0] = '{3, {8'h03, 8'h02, 8'h01}, 1'b0, '{8'h01, 8'h02, 8'h03, 2'd3, 1'b0}};
    vt[1] = '{2, {8'h00, 8'h10, 8'hFF}, 1'b1, '{8'hFF, 8'h10, 8'h00, 2'd2, 1'b1}};
    vt[2] = '{3, {8'h03, 8'h02, 8'h01}, 1'b0, '{8'h01, 8'h02, 8'h03, 2'd3, 1'b0}};
    vt[3] = '{3, {8'h06, 8'h05, 8'h04}, 1'b0, '{8'h04, 8'h05, 8'h06, 2'd3, 1'b0}};
    vt[4] = '{3, {8'h09, 8'h08, 8'h07}, 1'b0, '{8'h07, 8'h08, 8'h09, 2'd3, 1'b0}};
    vt[5] = '{1, {8'h00, 8'h00, 8'hAA}, 1'b1, '{8'hAA, 8'h00, 8'h00, 2'd1, 1'b1}};
    vt[6] = '{1, {8'h00, 8'h00, 8'hBB}, 1'b1, '{8'hBB, 8'h00, 8'h00, 2'd1, 1'b1}};
    vt[7] = '{3, {8'h33, 8'h22, 8'h11}, 1'b1, '{8'h11, 8'h22, 8'h33, 2'd3, 1'b1}};

    rst_n = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_fields", {bus.out_a, bus.out_b, bus.out_c, bus.out_count, bus.out_last}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", bus.in_ready, 1);
    step();

    // Back-to-back table: in_ready must never drop, groups issue at beat rate.
    xfer_cyc.delete();
    rdy_drops = 0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(vt[i].exp);
      for (int j = 0; j < vt[i].n; j++) begin
        if (!bus.in_ready) rdy_drops++;
        send(vt[i].d[j], (j == vt[i].n - 1) ? vt[i].last : 1'b0);
      end
    end
    drain();
    check("stream_in_ready_drops", rdy_drops, 0);
    check("stream_xfers", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8)
      for (int i = 1; i < 8; i++)
        check($sformatf("gap_%0d", i), xfer_cyc[i] - xfer_cyc[i-1], vt[i].n);

    // Stalled output: second group parks in HOLD.
    bus.out_ready = 1'b0;
    push(8'h04, 8'h05, 8'h06, 2'd3, 1'b0);
    push(8'h07, 8'h08, 8'h09, 2'd3, 1'b0);
    for (int k = 4; k <= 9; k++) send(k[N-1:0], 1'b0);
    @(negedge clk);
    check("hold_in_ready", bus.in_ready, 0);
    check("hold_out_a", {bus.out_valid, bus.out_a}, {1'b1, 8'h04});
    step(); step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_exit_cycle_in_ready", bus.in_ready, 0);
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("hold_exit_in_ready", bus.in_ready, 1);
    check("hold_exit_group", {bus.out_valid, bus.out_a, bus.out_c, bus.out_count},
          {1'b1, 8'h07, 8'h09, 2'd3});
    step();
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of a group discards the partial operands.
    push(8'h03, 8'h04, 8'h05, 2'd3, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", bus.in_ready, 1);
    check("postrst_out_valid", bus.out_valid, 0);
    step();
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'h05, 1'b0);
    drain();

    repeat (3) step();
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
